paint_scheduler: RTL
====================

// Module: paint_scheduler
// PURPOSE
// - Sequences the single-cell box painter: owns its start/busy/done handshake, cell->pixel mapping and paint order.
// - Serves two requesters: full-board clear and piece move (erase old 4 cells, draw new 4 cells).
// - Sits between gamelogic (piece cells, move/gravity events) and render_box20.
// PARAMETERS
// COLS     10   board columns
// ROWS     20   board rows
// CELL_W   64   pixel width of a cell (x0 = cx*CELL_W)
// CELL_H   24   pixel height of a cell (y0 = cy*CELL_H)
// BG_COLOR 0    9-bit RGB333 colour used for clear and erase
// PORTS
// CLOCK_50     in   1   system clock
// resetn       in   1   asynchronous active-low reset
// req_clear    in   1   1-cycle pulse: repaint whole board with BG_COLOR
// req_move     in   1   1-cycle pulse: piece now occupies new_cells
// new_cells    in   36  4 cells packed {y3,x3,...,y0,x0}, 5b y + 4b x each
// new_color    in   9   piece colour, sampled with req_move
// paint_busy   in   1   painter busy
// paint_done   in   1   painter 1-cycle completion pulse
// kick         out  1   1-cycle painter start
// x0           out  10  pixel x of cell to paint
// y0           out  9   pixel y of cell to paint
// color        out  9   paint colour
// sched_busy   out  1   high whenever state != IDLE or any request pending
// frame_done   out  1   1-cycle pulse when a clear or move sequence completes
// BEHAVIOUR
// - Reset: kick=0, x0=0, y0=0, color=0, frame_done=0, pending flags=0, committed_valid=0;
//   state=CLR_ISSUE (power-up clear runs automatically). Async reset mid-op aborts at once.
// - Requests latched into pend_clear / pend_move in any state; req_move overwrites pend cells+colour
//   (coalesce: only latest target kept). Simultaneous req_clear+req_move: both latched.
// - States: IDLE, CLR_ISSUE, CLR_WAIT, ER_ISSUE, ER_WAIT, DR_ISSUE, DR_WAIT.
// - ISSUE states: when !paint_busy and !kick, drive x0/y0/color, kick=1 for one cycle, go WAIT.
//   x0/y0/color hold stable from kick until paint_done. WAIT: advance only on paint_done.
// - IDLE priority: pend_clear > pend_move. Taking a request clears its pend flag that cycle.
// - Clear: raster clr_x 0..COLS-1 inner, clr_y 0..ROWS-1 outer, BG_COLOR; 200 kicks.
//   End: committed_valid=0, frame_done=1; if pend_move, move starts next IDLE cycle.
// - Move: copy pend cells to tgt regs. Erase phase idx 0..3 over committed cells, BG_COLOR;
//   skip cell (no kick, 1 cycle) if committed_valid=0 or it equals any tgt cell.
//   Draw phase idx 0..3 over tgt cells in tgt colour, always kicked.
//   End: committed<=tgt, committed_valid=1, frame_done=1, state IDLE.
// - req_clear during move: current painter op finishes; sequence continues to end (no abort);
//   clear served next from IDLE. req_move during move: pending, rerun after completion.
// - Coords outside COLS/ROWS: cell skipped entirely (no kick); not committed as visible.
// - Arithmetic: x0 = {cx,6'b0} when CELL_W=64; y0 = cy*CELL_H truncated to 9 bits (max 456).
// - paint_done outside WAIT ignored. kick never asserted while paint_busy=1.
// STRUCTURE
// - Shared package/include: COLS, ROWS, CELL_W, CELL_H, BG_COLOR, cell field widths, state encoding.
// - One sub-module: cell_to_pixel (cx,cy -> x0,y0, valid); datapath muxes and FSM stay local.
// TESTING
// - Reset release, painter model 20-cycle busy -> 200 kicks BG, order (0,0),(64,0)..(576,456); frame_done once.
// - After clear, req_move cells (4,0)(5,0)(4,1)(5,1) colour 9'h1C7 -> 4 draw kicks only, no erase.
// - req_move same piece +1 row -> 2 erase kicks (y=0 cells), 4 draw kicks at y0=24/48.
// - Three req_move pulses during one sequence -> exactly one rerun, using the last cells.
// - req_clear+req_move same cycle from IDLE -> full clear first, then 4 draw kicks, 2 frame_done.
// - Assert resetn low mid-DR_WAIT -> kick/outputs 0 immediately; after release, clear restarts at (0,0).

Source files
------------

// File: rtl/paint_scheduler_pkg.sv
// Shared constants, cell layout and FSM encoding for the box-painter scheduler.
package paint_scheduler_pkg;

    localparam int unsigned COLS      = 10;
    localparam int unsigned ROWS      = 20;
    localparam int unsigned CELL_W    = 64;
    localparam int unsigned CELL_H    = 24;
    localparam int unsigned CX_W      = 4;
    localparam int unsigned CY_W      = 5;
    localparam int unsigned CELL_BITS = CX_W + CY_W;
    localparam int unsigned NCELLS    = 4;
    localparam int unsigned CELLS_W   = NCELLS * CELL_BITS;
    localparam int unsigned PX_W      = 10;
    localparam int unsigned PY_W      = 9;
    localparam int unsigned COLOR_W   = 9;

    localparam logic [COLOR_W-1:0] BG_COLOR = 9'h000;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLR_ISSUE = 3'd1;
    localparam logic [2:0] S_CLR_WAIT  = 3'd2;
    localparam logic [2:0] S_ER_ISSUE  = 3'd3;
    localparam logic [2:0] S_ER_WAIT   = 3'd4;
    localparam logic [2:0] S_DR_ISSUE  = 3'd5;
    localparam logic [2:0] S_DR_WAIT   = 3'd6;

    typedef struct packed {
        logic [CY_W-1:0] y;
        logic [CX_W-1:0] x;
    } cell_t;

    // Extract cell idx from the packed {y3,x3,...,y0,x0} vector.
    function automatic cell_t cell_at(input logic [CELLS_W-1:0] cells, input logic [1:0] idx);
        return cells[32'(idx)*CELL_BITS +: CELL_BITS];
    endfunction

endpackage

// File: rtl/paint_scheduler_if.sv
// Requester and painter handshake bundle seen by the scheduler.
interface paint_scheduler_if;
    import paint_scheduler_pkg::*;

    logic                 req_clear;
    logic                 req_move;
    logic [CELLS_W-1:0]   new_cells;
    logic [COLOR_W-1:0]   new_color;
    logic                 paint_busy;
    logic                 paint_done;
    logic                 kick;
    logic [PX_W-1:0]      x0;
    logic [PY_W-1:0]      y0;
    logic [COLOR_W-1:0]   color;
    logic                 sched_busy;
    logic                 frame_done;

    modport master (
        input  req_clear, req_move, new_cells, new_color, paint_busy, paint_done,
        output kick, x0, y0, color, sched_busy, frame_done
    );

    modport slave (
        output req_clear, req_move, new_cells, new_color, paint_busy, paint_done,
        input  kick, x0, y0, color, sched_busy, frame_done
    );

endinterface

// File: rtl/paint_scheduler_cell_to_pixel.sv
// Board cell coordinate to pixel origin, with on-board range flag.
module paint_scheduler_cell_to_pixel
    import paint_scheduler_pkg::*;
(
    input  logic [CX_W-1:0] cx_i,
    input  logic [CY_W-1:0] cy_i,
    output logic [PX_W-1:0] x0_c_o,
    output logic [PY_W-1:0] y0_c_o,
    output logic            valid_c_o
);

    assign x0_c_o    = PX_W'(cx_i) * PX_W'(CELL_W);
    assign y0_c_o    = PY_W'(cy_i) * PY_W'(CELL_H);
    assign valid_c_o = (32'(cx_i) < COLS) && (32'(cy_i) < ROWS);

endmodule

// File: rtl/paint_scheduler.sv
// Sequences board clears and piece erase/draw moves onto the single-cell box painter.
module paint_scheduler
    import paint_scheduler_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               resetn,
    paint_scheduler_if.master  bus
);

    logic [2:0]          state_q, state_d;
    logic                pend_clear_q, pend_clear_d;
    logic                pend_move_q, pend_move_d;
    logic [CELLS_W-1:0]  pend_cells_q, pend_cells_d;
    logic [COLOR_W-1:0]  pend_color_q, pend_color_d;
    logic [CELLS_W-1:0]  tgt_cells_q, tgt_cells_d;
    logic [COLOR_W-1:0]  tgt_color_q, tgt_color_d;
    logic [CELLS_W-1:0]  com_cells_q, com_cells_d;
    logic                com_valid_q, com_valid_d;
    logic [1:0]          idx_q, idx_d;
    logic [CX_W-1:0]     clr_x_q, clr_x_d;
    logic [CY_W-1:0]     clr_y_q, clr_y_d;
    logic                kick_q, kick_d;
    logic [PX_W-1:0]     x0_q, x0_d;
    logic [PY_W-1:0]     y0_q, y0_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic                frame_done_q, frame_done_d;
    logic                sched_busy_q, sched_busy_d;

    cell_t               cur_cell;
    logic                hit_tgt;
    logic                issue_ok;
    logic                er_adv, dr_adv;
    logic [PX_W-1:0]     px_x;
    logic [PY_W-1:0]     px_y;
    logic                px_valid;

    // Cell currently addressed by the active phase.
    always_comb begin
        cur_cell = '0;
        case (state_q)
            S_CLR_ISSUE, S_CLR_WAIT: cur_cell = {clr_y_q, clr_x_q};
            S_ER_ISSUE, S_ER_WAIT:   cur_cell = cell_at(com_cells_q, idx_q);
            S_DR_ISSUE, S_DR_WAIT:   cur_cell = cell_at(tgt_cells_q, idx_q);
            default:                 cur_cell = '0;
        endcase
    end

    // Old cells still covered by the new piece need no erase.
    always_comb begin
        hit_tgt = 1'b0;
        for (int unsigned i = 0; i < NCELLS; i++) begin
            if (cell_at(tgt_cells_q, 2'(i)) == cur_cell) hit_tgt = 1'b1;
        end
    end

    paint_scheduler_cell_to_pixel u_c2p (
        .cx_i      (cur_cell.x),
        .cy_i      (cur_cell.y),
        .x0_c_o    (px_x),
        .y0_c_o    (px_y),
        .valid_c_o (px_valid)
    );

    assign issue_ok = !bus.paint_busy && !kick_q;

    always_comb begin
        state_d      = state_q;
        pend_clear_d = pend_clear_q | bus.req_clear;
        pend_move_d  = pend_move_q | bus.req_move;
        pend_cells_d = bus.req_move ? bus.new_cells : pend_cells_q;
        pend_color_d = bus.req_move ? bus.new_color : pend_color_q;
        tgt_cells_d  = tgt_cells_q;
        tgt_color_d  = tgt_color_q;
        com_cells_d  = com_cells_q;
        com_valid_d  = com_valid_q;
        idx_d        = idx_q;
        clr_x_d      = clr_x_q;
        clr_y_d      = clr_y_q;
        kick_d       = 1'b0;
        x0_d         = x0_q;
        y0_d         = y0_q;
        color_d      = color_q;
        frame_done_d = 1'b0;
        er_adv       = 1'b0;
        dr_adv       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_clear_q) begin
                    pend_clear_d = bus.req_clear;
                    clr_x_d      = '0;
                    clr_y_d      = '0;
                    state_d      = S_CLR_ISSUE;
                end else if (pend_move_q) begin
                    pend_move_d  = bus.req_move;
                    tgt_cells_d  = pend_cells_q;
                    tgt_color_d  = pend_color_q;
                    idx_d        = '0;
                    state_d      = S_ER_ISSUE;
                end
            end
            S_CLR_ISSUE: begin
                if (issue_ok) begin
                    x0_d    = px_x;
                    y0_d    = px_y;
                    color_d = BG_COLOR;
                    kick_d  = 1'b1;
                    state_d = S_CLR_WAIT;
                end
            end
            S_CLR_WAIT: begin
                if (bus.paint_done) begin
                    state_d = S_CLR_ISSUE;
                    if (clr_x_q == CX_W'(COLS - 1)) begin
                        clr_x_d = '0;
                        if (clr_y_q == CY_W'(ROWS - 1)) begin
                            com_valid_d  = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            clr_y_d = clr_y_q + CY_W'(1);
                        end
                    end else begin
                        clr_x_d = clr_x_q + CX_W'(1);
                    end
                end
            end
            S_ER_ISSUE: begin
                if (!com_valid_q || !px_valid || hit_tgt) begin
                    er_adv = 1'b1;
                end else if (issue_ok) begin
                    x0_d    = px_x;
                    y0_d    = px_y;
                    color_d = BG_COLOR;
                    kick_d  = 1'b1;
                    state_d = S_ER_WAIT;
                end
            end
            S_ER_WAIT: er_adv = bus.paint_done;
            S_DR_ISSUE: begin
                if (!px_valid) begin
                    dr_adv = 1'b1;
                end else if (issue_ok) begin
                    x0_d    = px_x;
                    y0_d    = px_y;
                    color_d = tgt_color_q;
                    kick_d  = 1'b1;
                    state_d = S_DR_WAIT;
                end
            end
            S_DR_WAIT: dr_adv = bus.paint_done;
            default: state_d = S_IDLE;
        endcase

        if (er_adv) begin
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q == 2'd3) ? S_DR_ISSUE : S_ER_ISSUE;
        end

        // Last draw slot commits the new piece as the visible one.
        if (dr_adv) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                com_cells_d  = tgt_cells_q;
                com_valid_d  = 1'b1;
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end else begin
                state_d = S_DR_ISSUE;
            end
        end

        sched_busy_d = (state_d != S_IDLE) || pend_clear_d || pend_move_d;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_CLR_ISSUE;
            pend_clear_q <= 1'b0;
            pend_move_q  <= 1'b0;
            pend_cells_q <= '0;
            pend_color_q <= '0;
            tgt_cells_q  <= '0;
            tgt_color_q  <= '0;
            com_cells_q  <= '0;
            com_valid_q  <= 1'b0;
            idx_q        <= '0;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
            kick_q       <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            color_q      <= '0;
            frame_done_q <= 1'b0;
            sched_busy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_clear_q <= pend_clear_d;
            pend_move_q  <= pend_move_d;
            pend_cells_q <= pend_cells_d;
            pend_color_q <= pend_color_d;
            tgt_cells_q  <= tgt_cells_d;
            tgt_color_q  <= tgt_color_d;
            com_cells_q  <= com_cells_d;
            com_valid_q  <= com_valid_d;
            idx_q        <= idx_d;
            clr_x_q      <= clr_x_d;
            clr_y_q      <= clr_y_d;
            kick_q       <= kick_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            color_q      <= color_d;
            frame_done_q <= frame_done_d;
            sched_busy_q <= sched_busy_d;
        end
    end

    assign bus.kick       = kick_q;
    assign bus.x0         = x0_q;
    assign bus.y0         = y0_q;
    assign bus.color      = color_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sched_busy = sched_busy_q;

endmodule
